led_fader: RTL
==============

Name: led_fader

Overview:
- Downstream stage of the Blink/Top LED path. It consumes the square-wave `led_o` level produced by Blink and drives the physical LED with a PWM "breathing" output.
- On each level change of the input, brightness ramps linearly up or down instead of switching hard.
- Sits between Blink's output and the board LED pin in the same single clock domain.

Parameters:
- FREQ, 50_000_000, clock frequency in Hz; 0 is illegal (elaboration $error).
- RAMP_MS, 250, full 0→max ramp time in ms; 0 is illegal (elaboration $error).
- PWM_BITS, 8, brightness resolution; MAX = 2**PWM_BITS-1; legal range 2..12.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  reset.
- led_i  input  1  LED level from Blink (same clock domain).
- led_o  output  1  PWM drive to LED pin, registered.
- level_o  output  PWM_BITS  current brightness level.
- busy_o  output  1  high while a ramp is in progress.

Interface decision: one clock (clk_i); rst_i is synchronous and active-high.

Behaviour:
- Reset (rst_i=1 at a clk_i edge):
  - state=OFF, level=0, duty=0.
  - Prescaler and PWM counters = 0.
  - led_q = 0, led_o = 0, busy_o = 0.
  - Applies mid-ramp too, with no residual state.
- Input register:
  - led_q <= led_i every cycle.
  - target = led_q ? MAX : 0.
- STEP_DIV = max(1, ((FREQ/1000)*RAMP_MS) >> PWM_BITS), computed at elaboration with 64-bit arithmetic.
- Prescaler:
  - Counts 0..STEP_DIV-1 only in RAMP_UP/RAMP_DOWN.
  - Cleared on every state change.
  - step = (presc == STEP_DIV-1).
- FSM states: OFF, RAMP_UP, ON, RAMP_DOWN.
  - OFF: led_q=1 → RAMP_UP.
  - RAMP_UP:
    - On step, level+1; when level reaches MAX on that step → ON.
    - led_q=0 → RAMP_DOWN immediately; level holds, no jump.
  - ON: led_q=0 → RAMP_DOWN.
  - RAMP_DOWN:
    - On step, level-1; when level reaches 0 → OFF.
    - led_q=1 → RAMP_UP immediately.
  - level never wraps: saturates at 0 and MAX.
  - Direction reversal takes priority over step in the same cycle; that step is discarded.
- Latency:
  - led_i edge → state change visible 2 cycles later (led_q, then state).
  - busy_o = (state==RAMP_UP || state==RAMP_DOWN), registered with the state.
- PWM:
  - pwm_cnt free-runs 0..MAX-1 (period MAX cycles).
  - duty <= level only when pwm_cnt==MAX-1 (glitch-free update at period boundary).
  - led_o <= (pwm_cnt < duty).
  - duty=0 → constant 0; duty=MAX → constant 1.
- level_o = level (registered).
- Ramp duration 0→MAX = MAX*STEP_DIV cycles.
- An input pulse shorter than 1 cycle is not guaranteed to be seen.

Decomposition:
- Package blink_pkg:
  - typedef enum logic [1:0] {OFF, RAMP_UP, ON, RAMP_DOWN} fader_state_t.
  - function step_div(freq, ramp_ms, pwm_bits) returning the saturated divider.
- One sub-module, pwm_gen:
  - Parameter PWM_BITS; ports clk_i, rst_i, level_i, pwm_o.
  - Owns pwm_cnt, the duty latch and the led_o register.
- led_fader owns the input register, the FSM, the prescaler and level.

Test Plan (FREQ=1_024_000, RAMP_MS=1, PWM_BITS=4 → MAX=15, STEP_DIV=64, ramp=960 cycles, PWM period 15):
- Reset: hold rst_i 3 cycles with led_i=1.
  - While rst_i is high: led_o=0, level_o=0, busy_o=0.
  - After release: busy_o=1 at cycle 2.
- Full ramp up: led_i 0→1, held.
  - busy_o rises 2 cycles after.
  - level_o increments every 64 cycles; level_o=15 and busy_o=0 at 962±1 cycles.
  - Then led_o constantly 1.
- Reversal: led_i=1 for 300 cycles, then 0.
  - level_o peaks at 4, then decrements every 64 cycles with no jump.
  - Reaches 0 with state OFF; led_o then constantly 0.
- Duty check: force steady level 5 via a mid-ramp freeze scenario.
  - led_o high exactly 5 of every 15 cycles.
  - duty changes only on PWM period boundaries.
- Reset mid-ramp: assert rst_i at level_o=7.
  - Next cycle: level_o=0, busy_o=0, led_o=0.
  - With led_i still 1, the ramp restarts from 0.
- Illegal parameters: elaborate with RAMP_MS=0 → $error at elaboration.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared types and elaboration helpers for the LED fader path.
// Holds the fader state encoding and the ramp step divider calculation.
package blink_pkg;

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    RAMP_UP   = 2'd1,
    ON        = 2'd2,
    RAMP_DOWN = 2'd3
  } fader_state_t;

  localparam int unsigned PWM_BITS_MIN = 2;
  localparam int unsigned PWM_BITS_MAX = 12;

  // Cycles per brightness step; never below 1 so very fast ramps still advance.
  function automatic longint unsigned step_div(input longint unsigned freq,
                                               input longint unsigned ramp_ms,
                                               input int unsigned pwm_bits);
    longint unsigned prod;
    prod = (freq / 64'd1000) * ramp_ms;
    prod = prod >> pwm_bits;
    return (prod == 64'd0) ? 64'd1 : prod;
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// PWM output stage: free-running period counter, duty latch and output register.
// Duty is taken from level_i only at the period boundary so a period is never split.
module pwm_gen #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [PWM_BITS-1:0] level_i,
  output logic                pwm_o
);

  localparam logic [PWM_BITS-1:0] CNT_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                pwm_q, pwm_d;

  always_comb begin
    cnt_d  = cnt_q + {{(PWM_BITS-1){1'b0}}, 1'b1};
    duty_d = duty_q;
    pwm_d  = (cnt_q < duty_q);
    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      duty_d = level_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/led_fader.sv
// Breathing LED driver: ramps brightness linearly toward the Blink level and drives a PWM pin.
//
// state     | meaning
// OFF       | level at 0, input low, idle
// RAMP_UP   | level climbing one step per STEP_DIV cycles
// ON        | level at MAX, input high, idle
// RAMP_DOWN | level falling one step per STEP_DIV cycles
module led_fader
  import blink_pkg::*;
#(
  parameter int unsigned FREQ     = 50_000_000,
  parameter int unsigned RAMP_MS  = 250,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                led_i,
  output logic                led_o,
  output logic [PWM_BITS-1:0] level_o,
  output logic                busy_o
);

  localparam longint unsigned STEP_DIV = step_div(64'(FREQ), 64'(RAMP_MS), PWM_BITS);
  localparam int unsigned     PRESC_W  = (STEP_DIV > 64'd1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(STEP_DIV - 64'd1);
  localparam logic [PWM_BITS-1:0] LEVEL_MAX  = '1;
  localparam logic [PWM_BITS-1:0] LEVEL_ONE  = {{(PWM_BITS-1){1'b0}}, 1'b1};

  if (FREQ == 0) begin : g_bad_freq
    $error("led_fader: FREQ must be nonzero");
  end
  if (RAMP_MS == 0) begin : g_bad_ramp
    $error("led_fader: RAMP_MS must be nonzero");
  end
  if (PWM_BITS < PWM_BITS_MIN || PWM_BITS > PWM_BITS_MAX) begin : g_bad_bits
    $error("led_fader: PWM_BITS must be within 2..12");
  end

  fader_state_t        state_q, state_d;
  logic                led_q, led_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic                busy_q, busy_d;
  logic                step;

  always_comb begin
    led_d   = led_i;
    state_d = state_q;
    level_d = level_q;
    presc_d = '0;
    step    = (presc_q == PRESC_LAST);

    // A reversal wins over a coincident step; that step is simply dropped.
    unique case (state_q)
      OFF: begin
        if (led_q) state_d = RAMP_UP;
      end
      RAMP_UP: begin
        if (!led_q) begin
          state_d = RAMP_DOWN;
        end else if (step) begin
          if (level_q != LEVEL_MAX) level_d = level_q + LEVEL_ONE;
          if (level_q >= LEVEL_MAX - LEVEL_ONE) state_d = ON;
        end
      end
      ON: begin
        if (!led_q) state_d = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (led_q) begin
          state_d = RAMP_UP;
        end else if (step) begin
          if (level_q != '0) level_d = level_q - LEVEL_ONE;
          if (level_q <= LEVEL_ONE) state_d = OFF;
        end
      end
      default: state_d = OFF;
    endcase

    if ((state_d == state_q) && (state_q == RAMP_UP || state_q == RAMP_DOWN)) begin
      presc_d = step ? '0 : presc_q + PRESC_W'(1);
    end

    busy_d = (state_d == RAMP_UP) || (state_d == RAMP_DOWN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= OFF;
      led_q   <= 1'b0;
      level_q <= '0;
      presc_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      level_q <= level_d;
      presc_q <= presc_d;
      busy_q  <= busy_d;
    end
  end

  pwm_gen #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .level_i(level_q),
    .pwm_o  (led_o)
  );

  assign level_o = level_q;
  assign busy_o  = busy_q;

endmodule
